cross_clock_bus: RTL and testbench
==================================

# cross_clock_bus

Parametrised multi-channel successor to the single-word quasi-static crossing. It brings CHANNELS independent, slowly-changing words from a foreign or asynchronous domain into `out_clk` through a configurable-depth synchroniser. Each channel has a stability filter, a one-cycle change strobe, a valid flag and a synchronous hold. It sits at every status/config boundary where a slow register bank crosses into the sample-clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per channel.
- `CHANNELS`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per bit (≥2).
- `STABLE_CYCLES`, 2: consecutive equal post-sync samples required before output update (≥1).

Ports:
- `out_clk`  in  1  sole clock; all state clocked on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `in_data`  in  CHANNELS*DATA_WIDTH  asynchronous input. Channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- `hold`  in  1  synchronous to `out_clk`; freezes all outputs while high.
- `out_data`  out  CHANNELS*DATA_WIDTH  filtered, registered output; same packing as `in_data`.
- `out_changed`  out  CHANNELS  per-channel one-cycle strobe on output update with a new value.
- `out_valid`  out  CHANNELS  per-channel flag; sticky high after the first qualified sample following reset.
- `out_any_changed`  out  1  registered OR of the `out_changed` conditions; asserts in the same cycle as `out_changed`.

## Operation
Per channel c, fully independent:
- Sync chain: `s[0] <= in_c`; `s[k] <= s[k-1]`. `last = s[SYNC_STAGES-1]`.
- Previous sample: `prev <= last` every edge.
- `match = (last == prev)`, over the full DATA_WIDTH.
- Stability counter `cnt`, width max(1, clog2(STABLE_CYCLES)):
  - cleared on `!match`;
  - otherwise increments, saturating at STABLE_CYCLES-1.
- `qualified = match && (cnt == STABLE_CYCLES-1)`. When STABLE_CYCLES=1, `qualified = match`.
- Update condition: `qualified && !hold && (last != out_c || !out_valid[c])`. On update:
  - `out_c <= last`;
  - `out_valid[c] <= 1`;
  - `out_changed[c] <= (last != out_c)`.
- Otherwise `out_changed[c] <= 0`, and `out_c` and `out_valid[c]` keep their values.
- The first update after reset sets `out_valid` even when the value equals 0. In that case `out_changed` stays 0.
- `hold` does not affect the sync chain, `prev` or `cnt`; filtering continues during hold.
- On `hold` release with the channel still qualified, the update fires on the first edge with `hold` = 0.
- Any input change shorter than the filter window never reaches `out_data`.

Reset (`rst_n` = 0, asynchronous assert; deassertion is synchronised externally by the system reset block):
- All sync stages, `prev`, `cnt`, `out_data`, `out_valid`, `out_changed` and `out_any_changed` = 0.
- Reset mid-filter discards the pending value; the full latency restarts after deassertion.

## Timing
- Latency: a step on `in_c` settling before edge 1 appears on `out_c` after edge `SYNC_STAGES + 1 + STABLE_CYCLES`, provided `hold` = 0. `out_changed[c]` is high in the cycle following that edge.
  - Defaults: 2+1+2 = 5 edges.
- `out_changed` is strictly one cycle per update. A continuously stable input never re-strobes.
- Channels updating on the same edge strobe simultaneously; `out_any_changed` = 1 in that one cycle.
- Single-cycle input pulse, defaults: `cnt` never reaches 1 with a match on the pulse value, so no update occurs.
- `in_data` is not required to be bus-coherent. Multi-bit skew resolves because an update requires STABLE_CYCLES+1 identical post-sync samples.

## Test plan
- Reset/first sample, defaults: hold `in_data` = 0 through reset release. `out_valid` = 4'hF after edge 5, `out_changed` stays 0, `out_data` = 0.
- Step latency: channel 2 steps 0x00→0xA5 one cycle before edge 1. `out_data[23:16]` = 0xA5 and `out_changed` = 4'b0100 for exactly one cycle after edge 5. Other channels are unchanged.
- Glitch rejection, STABLE_CYCLES=2: channel 0 goes 0x00→0x3C for one cycle, then back. No update and no strobe. A 2-cycle pulse with STABLE_CYCLES=3 is also rejected.
- Hold: channel 1 steps to 0x7F with `hold` = 1 for 20 cycles. `out_data` stays old and no strobe. After `hold` drops, the update and strobe occur on the first edge.
- Simultaneous channels plus async reset: channels 0 and 3 step on the same cycle, giving `out_changed` = 4'b1001 and `out_any_changed` = 1. Then pulse `rst_n` low mid-cycle: all outputs are 0 immediately, without waiting for an edge.
- Parameter sweep: SYNC_STAGES ∈ {2,3,4} and STABLE_CYCLES ∈ {1,2,5}, each with CHANNELS ∈ {1,4}. Measured latency equals SYNC_STAGES+1+STABLE_CYCLES in every case.

Source files
------------

// File: rtl/cross_clock_bus.sv
// cross_clock_bus
//   Brings CHANNELS slowly-changing words from an asynchronous domain into
//   out_clk. Each channel has an N-flop synchroniser, a stability filter that
//   needs STABLE_CYCLES+1 identical post-sync samples, a one-cycle change
//   strobe, a sticky valid flag and a synchronous hold.
//
// Ports
//   out_clk          sole clock, rising edge
//   rst_n            async active-low reset, clears all state
//   in_data          async input, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   hold             freezes out_data/out_valid (filtering keeps running)
//   out_data         filtered registered output, same packing as in_data
//   out_changed      per-channel one-cycle strobe on update with new value
//   out_valid        per-channel sticky flag, set by first qualified sample
//   out_any_changed  registered OR of the per-channel change conditions

// Per-channel lane: synchroniser, stability filter and output register.
module cross_clock_bus_lane #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                  out_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic                  hold_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  changed_o,
  output logic                  chg_d_o
);
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q, data_q, data_d, last;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d, chg_q, chg_d;
  logic                  match, qual, upd;

  always_comb begin
    last    = sync_q[SYNC_STAGES-1];
    match   = (last == prev_q);
    cnt_d   = '0;
    if (match) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    // With STABLE_CYCLES=1 CNT_MAX is 0, so qual collapses to match.
    qual    = match && (cnt_q == CNT_MAX);
    // First qualified sample after reset must set valid even if it equals 0.
    upd     = qual && !hold_i && ((last != data_q) || !valid_q);
    data_d  = upd ? last : data_q;
    valid_d = valid_q | upd;
    chg_d   = upd && (last != data_q);
  end

  always_ff @(posedge out_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_i};
      prev_q  <= last;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign changed_o = chg_q;
  assign chg_d_o   = chg_d;
endmodule

module cross_clock_bus #(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                           out_clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           hold,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]            out_changed,
  output logic [CHANNELS-1:0]            out_valid,
  output logic                           out_any_changed
);
  logic [CHANNELS-1:0] chg_d;
  logic                any_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    cross_clock_bus_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_lane (
      .out_clk  (out_clk),
      .rst_n    (rst_n),
      .in_i     (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .hold_i   (hold),
      .data_o   (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o  (out_valid[c]),
      .changed_o(out_changed[c]),
      .chg_d_o  (chg_d[c])
    );
  end

  // Registered from the lanes' next-state strobes so it lines up with out_changed.
  always_ff @(posedge out_clk or negedge rst_n) begin
    if (!rst_n) any_q <= 1'b0;
    else        any_q <= |chg_d;
  end

  assign out_any_changed = any_q;
endmodule

// File: tb/tb_cross_clock_bus.sv
module tb_cross_clock_bus;
  localparam int S = 2, T = 2, NRND = 400;

  logic        clk = 1'b0, rst_n = 1'b0, hold = 1'b0;
  logic [31:0] in0 = '0, d0_data;
  logic [3:0]  d0_chg, d0_vld;
  logic        d0_any;
  logic [7:0]  in3 = '0, d3_data;
  logic        d3_chg, d3_vld, d3_any;
  logic [31:0] sw_in = '0;
  logic [17:0][31:0] sw_out;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  cross_clock_bus u_d0 (
    .out_clk(clk), .rst_n(rst_n), .in_data(in0), .hold(hold),
    .out_data(d0_data), .out_changed(d0_chg), .out_valid(d0_vld),
    .out_any_changed(d0_any)
  );

  cross_clock_bus #(.CHANNELS(1), .STABLE_CYCLES(3)) u_d3 (
    .out_clk(clk), .rst_n(rst_n), .in_data(in3), .hold(1'b0),
    .out_data(d3_data), .out_changed(d3_chg), .out_valid(d3_vld),
    .out_any_changed(d3_any)
  );

  for (genvar i = 0; i < 3; i++) begin : g_s
    for (genvar j = 0; j < 3; j++) begin : g_t
      for (genvar k = 0; k < 2; k++) begin : g_c
        localparam int SS = 2 + i;
        localparam int TT = (j == 0) ? 1 : ((j == 1) ? 2 : 5);
        localparam int CC = (k == 0) ? 1 : 4;
        logic [CC*8-1:0] o;
        logic [CC-1:0]   ch, v;
        logic            a;
        cross_clock_bus #(.CHANNELS(CC), .SYNC_STAGES(SS), .STABLE_CYCLES(TT)) u (
          .out_clk(clk), .rst_n(rst_n), .in_data(sw_in[CC*8-1:0]), .hold(1'b0),
          .out_data(o), .out_changed(ch), .out_valid(v), .out_any_changed(a)
        );
        assign sw_out[i*6 + j*2 + k] = 32'(o);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hist [0:NRND-1];
    logic [31:0] mo, exps;
    logic [3:0]  echg;
    logic [7:0]  b;
    logic        q;
    int          lat [18];
    int          si, ti, ci;

    // reset state
    repeat (3) tick();
    chk("rst_data", d0_data, 32'h0);
    chk("rst_valid", 32'(d0_vld), 32'h0);
    chk("rst_chg", 32'(d0_chg), 32'h0);
    chk("rst_any", 32'(d0_any), 32'h0);
    rst_n = 1'b1;

    // first sample of zero: valid set, no strobe
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk("first_chg", 32'(d0_chg), 32'h0);
      chk("first_any", 32'(d0_any), 32'h0);
    end
    chk("first_valid", 32'(d0_vld), 32'hF);
    chk("first_data", d0_data, 32'h0);
    repeat (5) tick();

    // step latency on channel 2
    in0[23:16] = 8'hA5;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("step_data_e%0d", e), d0_data, (e >= 5) ? 32'h00A5_0000 : 32'h0);
      chk($sformatf("step_chg_e%0d", e), 32'(d0_chg), (e == 5) ? 32'h4 : 32'h0);
    end

    // single-cycle glitch on channel 0
    in0[7:0] = 8'h3C;
    tick();
    in0[7:0] = 8'h00;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("glitch_data", d0_data, 32'h00A5_0000);
      chk("glitch_chg", 32'(d0_chg), 32'h0);
    end

    // two-cycle pulse against STABLE_CYCLES=3, then a real step
    in3 = 8'h3C;
    tick();
    tick();
    in3 = 8'h00;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk("glitch3_data", 32'(d3_data), 32'h0);
      chk("glitch3_chg", 32'(d3_chg), 32'h0);
    end
    in3 = 8'h3C;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("step3_e%0d", e), 32'(d3_data), (e >= 6) ? 32'h3C : 32'h0);
    end

    // hold
    hold = 1'b1;
    in0[15:8] = 8'h7F;
    for (int e = 0; e < 20; e++) begin
      tick();
      chk("hold_data", d0_data, 32'h00A5_0000);
      chk("hold_chg", 32'(d0_chg), 32'h0);
    end
    hold = 1'b0;
    tick();
    chk("release_data", d0_data, 32'h00A5_7F00);
    chk("release_chg", 32'(d0_chg), 32'h2);
    tick();
    chk("release_chg_once", 32'(d0_chg), 32'h0);

    // simultaneous channels 0 and 3
    in0[7:0]   = 8'h11;
    in0[31:24] = 8'h22;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("sim_data_e%0d", e), d0_data, (e >= 5) ? 32'h22A5_7F11 : 32'h00A5_7F00);
      chk($sformatf("sim_chg_e%0d", e), 32'(d0_chg), (e == 5) ? 32'h9 : 32'h0);
      chk($sformatf("sim_any_e%0d", e), 32'(d0_any), (e == 5) ? 32'h1 : 32'h0);
    end

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", d0_data, 32'h0);
    chk("arst_valid", 32'(d0_vld), 32'h0);
    chk("arst_chg", 32'(d0_chg), 32'h0);
    chk("arst_any", 32'(d0_any), 32'h0);
    chk("arst_d3", 32'(d3_data), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // full latency restarts after reset with the input already stable
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("rerun_data_e%0d", e), d0_data, (e >= 5) ? in0 : 32'h0);
      chk($sformatf("rerun_chg_e%0d", e), 32'(d0_chg), (e == 5) ? 32'hF : 32'h0);
    end

    // parameter sweep: measure step latency of every configuration
    repeat (4) tick();
    sw_in = $urandom | 32'h0101_0101;
    foreach (lat[x]) lat[x] = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      for (int x = 0; x < 18; x++) begin
        ci = ((x % 2) == 0) ? 1 : 4;
        exps = (ci == 1) ? {24'h0, sw_in[7:0]} : sw_in;
        if (lat[x] == 0 && sw_out[x] == exps) lat[x] = e;
      end
    end
    for (int x = 0; x < 18; x++) begin
      si = 2 + x / 6;
      ti = ((x / 2) % 3 == 0) ? 1 : (((x / 2) % 3 == 1) ? 2 : 5);
      ci = ((x % 2) == 0) ? 1 : 4;
      chk($sformatf("sweep_lat_s%0d_t%0d_c%0d", si, ti, ci), 32'(lat[x]), 32'(si + 1 + ti));
    end

    // randomized run: an update at edge e needs the T+1 input samples seen at
    // edges e-S-T .. e-S to agree, and hold low at edge e
    for (int e = 0; e < 10; e++) hist[e] = in0;
    mo = in0;
    for (int e = 10; e < NRND; e++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       b = 8'h00;
            1:       b = 8'hFF;
            default: b = 8'($urandom);
          endcase
          in0[c*8 +: 8] = b;
        end
      end
      if ($urandom_range(0, 7) == 0) hold = ~hold;
      hist[e] = in0;
      tick();
      echg = '0;
      for (int c = 0; c < 4; c++) begin
        q = 1'b1;
        for (int t = 1; t <= T; t++)
          if (hist[e-S-t][c*8 +: 8] != hist[e-S][c*8 +: 8]) q = 1'b0;
        if (q && !hold && hist[e-S][c*8 +: 8] != mo[c*8 +: 8]) begin
          mo[c*8 +: 8] = hist[e-S][c*8 +: 8];
          echg[c] = 1'b1;
        end
      end
      chk($sformatf("rnd_data_e%0d", e), d0_data, mo);
      chk($sformatf("rnd_chg_e%0d", e), 32'(d0_chg), 32'(echg));
      chk($sformatf("rnd_any_e%0d", e), 32'(d0_any), 32'(|echg));
    end
    hold = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
